// File: rtl/fetch_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants, fetch FSM state encoding and small helpers
//               for the RV32I instruction-fetch stage and its pipeline
//               registers.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int XLEN = 32;

  // Default reset PC and the canonical NOP (addi x0,x0,0)
  localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;

  // Fetch FSM encodings
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,   // issue a request for pc
    ST_WAIT = 2'd1,   // one request outstanding, waiting for rvalid
    ST_HOLD = 2'd2    // response parked in the skid register (decode stalled)
  } fetch_state_e;

  // Sequential next-instruction address; wraps naturally at 2^XLEN
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + {{(XLEN-3){1'b0}}, 3'd4};
  endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Pipeline register carrying instruction, pc and pc+4 between
//               two stages, with stall (hold), flush and NOP insertion.
//               Whenever the register is invalid it presents NOP_INSTR.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               stall             - downstream cannot accept; hold contents
//               flush             - invalidate contents (wins over load)
//               load              - new word available this cycle
//               load_instr/pc/pc_plus4 - data captured on load
//               valid/instr/pc/pc_plus4 - registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_pc_plus4,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus4 <= pc_incr('0);
    end else if (flush) begin
      // pc/pc_plus4 are don't-care while invalid; leave them alone
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus4 <= load_pc_plus4;
    end else if (!stall) begin
      // contents consumed with nothing new behind them: insert a bubble
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage plus IF/ID register. Owns the
//               PC, keeps at most one request outstanding to instruction
//               memory, parks a response in a skid register when decode is
//               stalled, and honours redirects from execute by discarding
//               the in-flight response.
// Ports       : clk, rst                       - clock, sync active-high reset
//               imem_req/imem_addr/imem_ready  - request channel
//               imem_rvalid/imem_rdata         - response channel
//               id_stall, id_flush             - decode-side control
//               redirect_valid, redirect_pc    - execute-side PC redirect
//               id_valid/id_instr/id_pc/id_pc_plus4 - IF/ID outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            id_stall,
  input  logic            id_flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;          // next address to request
  logic [XLEN-1:0] r_inflight_pc; // address of the outstanding / parked word
  logic [XLEN-1:0] r_skid;        // parked instruction while in ST_HOLD
  logic            r_kill;        // outstanding response must be dropped

  logic            w_accept;
  logic            w_ifid_free;
  logic            w_wait_load;
  logic            w_hold_load;
  logic            w_load;
  logic [XLEN-1:0] w_load_instr;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_unused_redirect_lsbs;

  // Redirect targets are forced to word alignment
  assign w_redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

  // A redirect in ST_REQ suppresses the request so the stale pc never leaves
  assign imem_req  = (r_state == ST_REQ) && !redirect_valid && !rst;
  assign imem_addr = r_pc;
  assign w_accept  = imem_req && imem_ready;

  // IF/ID can take a word if it is empty or being consumed this cycle.
  // A flush in the same cycle would swallow the new word, so it is parked
  // in the skid register instead and delivered once the flush has passed.
  assign w_ifid_free = !id_valid || !id_stall;
  assign w_wait_load = (r_state == ST_WAIT) && imem_rvalid && !r_kill &&
                       !redirect_valid && w_ifid_free && !id_flush;
  assign w_hold_load = (r_state == ST_HOLD) && !redirect_valid &&
                       !id_stall && !id_flush;
  assign w_load       = w_wait_load || w_hold_load;
  assign w_load_instr = (r_state == ST_HOLD) ? r_skid : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_pc          <= {RESET_PC[XLEN-1:2], 2'b00};
      r_kill        <= 1'b0;
      r_inflight_pc <= '0;
      r_skid        <= '0;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
      unique case (r_state)
        ST_WAIT: begin
          if (imem_rvalid) begin
            // the response lands together with the redirect: just drop it
            r_kill  <= 1'b0;
            r_state <= ST_REQ;
          end else begin
            r_kill  <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_HOLD: r_state <= ST_REQ;
        default: r_state <= ST_REQ;
      endcase
    end else begin
      unique case (r_state)
        ST_REQ: begin
          if (w_accept) begin
            r_inflight_pc <= r_pc;
            r_pc          <= pc_incr(r_pc);
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= ST_REQ;
            end else if (w_wait_load) begin
              r_state <= ST_REQ;
            end else begin
              r_skid  <= imem_rdata;
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_hold_load) begin
            r_state <= ST_REQ;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  // A redirect invalidates IF/ID exactly like a flush, regardless of stall
  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (id_stall),
    .flush         (redirect_valid || id_flush),
    .load          (w_load),
    .load_instr    (w_load_instr),
    .load_pc       (r_inflight_pc),
    .load_pc_plus4 (pc_incr(r_inflight_pc)),
    .valid         (id_valid),
    .instr         (id_instr),
    .pc            (id_pc),
    .pc_plus4      (id_pc_plus4)
  );

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A cycle table covers
//               reset, first fetch, skid/HOLD and flush; hand-written
//               sequences cover redirects, PC wrap, slow memory and reset
//               mid-fetch; a randomised stream with a memory model and a
//               scoreboard queue checks ordering, pc and data end to end.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        id_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_stall       (id_stall),
    .id_flush       (id_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        rst, ready, rvalid;
    logic [31:0] rdata;
    logic        stall, flush, redir;
    logic [31:0] rpc;
    logic        chk;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(
    input logic rst_v, input logic ready_v, input logic rvalid_v, input logic [31:0] rdata_v,
    input logic stall_v, input logic flush_v, input logic redir_v, input logic [31:0] rpc_v,
    input logic chk_v, input logic e_req_v, input logic [31:0] e_addr_v,
    input logic e_valid_v, input logic [31:0] e_instr_v, input logic [31:0] e_pc_v);
    vec_t v;
    v.rst = rst_v; v.ready = ready_v; v.rvalid = rvalid_v; v.rdata = rdata_v;
    v.stall = stall_v; v.flush = flush_v; v.redir = redir_v; v.rpc = rpc_v;
    v.chk = chk_v; v.e_req = e_req_v; v.e_addr = e_addr_v;
    v.e_valid = e_valid_v; v.e_instr = e_instr_v; v.e_pc = e_pc_v;
    return v;
  endfunction

  // Drive one cycle of inputs just after the edge, check mid-cycle, advance.
  task automatic apply_vec(input vec_t v, input string tag);
    rst = v.rst; imem_ready = v.ready; imem_rvalid = v.rvalid; imem_rdata = v.rdata;
    id_stall = v.stall; id_flush = v.flush; redirect_valid = v.redir; redirect_pc = v.rpc;
    #3;
    if (v.chk) begin
      check1 ({tag, ".req"},   imem_req,  v.e_req);
      check32({tag, ".addr"},  imem_addr, v.e_addr);
      check1 ({tag, ".valid"}, id_valid,  v.e_valid);
      check32({tag, ".instr"}, id_instr,  v.e_instr);
      if (v.e_valid) begin
        check32({tag, ".pc"},    id_pc,       v.e_pc);
        check32({tag, ".pc4"},   id_pc_plus4, v.e_pc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------- hand-written sequences
  // Entered in WAIT with pc=0x18 (outstanding fetch of 0x14), IF/ID empty.
  task automatic seq_redirect_wait();
    apply_vec(mk(0,0,0,0,          0,0,1,32'h100, 1, 0,32'h18, 0,NOP,0), "rdw.redirect");
    apply_vec(mk(0,0,0,0,          0,0,0,0,       1, 0,32'h100,0,NOP,0), "rdw.wait");
    apply_vec(mk(0,0,1,32'h1111_1111,0,0,0,0,     1, 0,32'h100,0,NOP,0), "rdw.stale_rsp");
    apply_vec(mk(0,1,0,0,          0,0,0,0,       1, 1,32'h100,0,NOP,0), "rdw.new_req");
  endtask

  task automatic seq_redirect_misaligned();
    apply_vec(mk(0,0,1,32'h0010_0093,0,0,0,0,     1, 0,32'h104,0,NOP,0), "rdm.rsp");
    apply_vec(mk(0,1,0,0,          1,0,1,32'h203, 1, 0,32'h104,1,32'h0010_0093,32'h100), "rdm.redirect");
    apply_vec(mk(0,0,0,0,          0,0,0,0,       1, 1,32'h200,0,NOP,0), "rdm.aligned");
  endtask

  task automatic seq_pc_wrap();
    apply_vec(mk(0,0,0,0,          0,0,1,32'hFFFF_FFFC, 1, 0,32'h200,0,NOP,0), "wrap.redirect");
    for (int i = 0; i < 3; i++)
      apply_vec(mk(0,0,0,0,        0,0,0,0,       1, 1,32'hFFFF_FFFC,0,NOP,0), $sformatf("wrap.slow%0d", i));
    apply_vec(mk(0,1,0,0,          0,0,0,0,       1, 1,32'hFFFF_FFFC,0,NOP,0), "wrap.accept");
    apply_vec(mk(0,0,1,32'h0000_0513,0,0,0,0,     1, 0,32'h0,0,NOP,0), "wrap.rsp");
    apply_vec(mk(0,1,0,0,          0,0,0,0,       1, 1,32'h0,1,32'h0000_0513,32'hFFFF_FFFC), "wrap.ifid");
  endtask

  // Entered in WAIT with pc=4: a response after reset must be ignored.
  task automatic seq_mid_reset();
    apply_vec(mk(1,1,0,0,          0,0,0,0,       1, 0,32'h4,0,NOP,0), "mrst.rst");
    apply_vec(mk(0,0,1,32'h2222_2222,0,0,0,0,     1, 1,32'h0,0,NOP,0), "mrst.stale_rsp");
    apply_vec(mk(0,0,0,0,          0,0,0,0,       1, 1,32'h0,0,NOP,0), "mrst.idle");
  endtask

  // ---------------------------------------------- memory model + scoreboard
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];

  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] exp_pc = '0;
  int          n_pop = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic stream_step(input logic stall_v, input logic ready_en);
    logic accept;
    logic delivered;
    exp_t e;
    rst = 1'b0; id_flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    id_stall   = stall_v;
    imem_ready = ready_en && ($urandom_range(0, 3) != 0);
    delivered  = m_pend && (m_cnt == 0);
    imem_rvalid = delivered;
    imem_rdata  = delivered ? mem_word(m_addr) : $urandom;
    #3;
    check32("stream.addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
    check1("stream.one_outstanding", imem_req && m_pend, 1'b0);
    if (id_valid === 1'b1 && !stall_v) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL stream.unexpected: got pc %h with empty scoreboard", id_pc);
      end else begin
        e = sb.pop_front();
        n_pop++;
        check32("stream.instr", id_instr,    e.instr);
        check32("stream.pc",    id_pc,       e.pc);
        check32("stream.pc4",   id_pc_plus4, e.pc + 32'd4);
      end
    end
    accept = (imem_req === 1'b1) && imem_ready;
    if (accept) check32("stream.req_addr", imem_addr, exp_pc);
    @(posedge clk);
    if (delivered) begin
      e.pc = m_addr; e.instr = mem_word(m_addr);
      sb.push_back(e);
      m_pend = 1'b0;
    end
    if (accept) begin
      m_pend = 1'b1; m_addr = exp_pc; m_cnt = $urandom_range(0, 2);
      exp_pc = exp_pc + 32'd4;
    end else if (m_pend && m_cnt > 0) begin
      m_cnt--;
    end
    #1;
  endtask

  // ------------------------------------------------------------------ main
  vec_t tbl[15];

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_stall = 1'b0; id_flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // reset, first fetch, stall into HOLD, skid release, lone flush
    tbl[0]  = mk(1,0,0,0,            0,0,0,0, 0, 0,32'h0, 0,NOP,0);
    tbl[1]  = mk(1,0,0,0,            0,0,0,0, 1, 0,32'h0, 0,NOP,0);
    tbl[2]  = mk(0,1,0,0,            0,0,0,0, 1, 1,32'h0, 0,NOP,0);
    tbl[3]  = mk(0,1,1,32'h0050_0093,0,0,0,0, 1, 0,32'h4, 0,NOP,0);
    tbl[4]  = mk(0,1,0,0,            0,0,0,0, 1, 1,32'h4, 1,32'h0050_0093,32'h0);
    tbl[5]  = mk(0,1,1,32'h0020_0113,0,0,0,0, 1, 0,32'h8, 0,NOP,0);
    tbl[6]  = mk(0,1,0,0,            1,0,0,0, 1, 1,32'h8, 1,32'h0020_0113,32'h4);
    tbl[7]  = mk(0,1,1,32'h00A0_0113,1,0,0,0, 1, 0,32'hC, 1,32'h0020_0113,32'h4);
    tbl[8]  = mk(0,1,1,32'hDEAD_BEEF,1,0,0,0, 1, 0,32'hC, 1,32'h0020_0113,32'h4);
    tbl[9]  = mk(0,1,0,0,            0,0,0,0, 1, 0,32'hC, 1,32'h0020_0113,32'h4);
    tbl[10] = mk(0,1,0,0,            0,0,0,0, 1, 1,32'hC, 1,32'h00A0_0113,32'h8);
    tbl[11] = mk(0,1,1,32'h0030_0193,0,0,0,0, 1, 0,32'h10,0,NOP,0);
    tbl[12] = mk(0,1,0,0,            0,1,0,0, 1, 1,32'h10,1,32'h0030_0193,32'hC);
    tbl[13] = mk(0,1,1,32'h0040_0213,0,0,0,0, 1, 0,32'h14,0,NOP,0);
    tbl[14] = mk(0,1,0,0,            0,0,0,0, 1, 1,32'h14,1,32'h0040_0213,32'h10);

    for (int i = 0; i < 15; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    seq_redirect_wait();
    seq_redirect_misaligned();
    seq_pc_wrap();
    seq_mid_reset();

    // randomised stream from pc 0 with random stalls and memory latency
    for (int i = 0; i < 400; i++) stream_step($urandom_range(0, 2) == 0, 1'b1);
    for (int i = 0; i < 12; i++)  stream_step(1'b0, 1'b0);
    check32("stream.drained", sb.size(), 32'd0);
    check1("stream.progress", n_pop > 40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the RV32I core.
- Owns the PC and issues one outstanding request at a time to instruction memory.
- Presents the fetched word and its PC to decode; the immediate generator consumes id_instr[31:7].
- Accepts stall from decode and redirect/flush from execute (branches, jumps).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) driven on id_instr when invalid/flushed

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, always word aligned
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  instruction word
id_stall  input  1  decode cannot accept a new instruction; hold IF/ID
id_flush  input  1  invalidate IF/ID contents
redirect_valid  input  1  PC redirect from execute
redirect_pc  input  32  redirect target
id_valid  output  1  IF/ID holds a valid instruction
id_instr  output  32  instruction to decode
id_pc  output  32  PC of id_instr
id_pc_plus4  output  32  id_pc + 4

Behaviour:
- Reset (sync, rst=1 at edge):
  - pc=RESET_PC, state=REQ, kill=0.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=4.
  - imem_req=0 while rst is high.
- rst mid-operation: any in-flight response arriving after reset is ignored; the FSM restarts at REQ.
- FSM states:
  - REQ:
    - imem_req = !redirect_valid; imem_addr = pc.
    - On imem_req && imem_ready: inflight_pc<=pc, pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), go to WAIT.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid:
      - If kill or redirect_valid: discard the data, kill<=0, go to REQ.
      - Else if IF/ID is free (!id_valid || !id_stall): load IF/ID (id_instr=imem_rdata, id_pc=inflight_pc, id_valid=1), go to REQ.
      - Else: capture into the skid register and go to HOLD.
  - HOLD:
    - imem_req=0.
    - When !id_stall: load IF/ID from the skid register, go to REQ.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2],2'b00}; bits [1:0] are ignored.
  - IF/ID invalidated (id_valid=0, id_instr=NOP_INSTR).
  - In WAIT without rvalid: kill<=1, stay in WAIT.
  - In HOLD: skid register dropped, go to REQ.
  - In REQ: no request is issued that cycle; the next cycle requests the new pc.
- IF/ID register:
  - id_flush (without redirect): id_valid<=0, id_instr<=NOP_INSTR; the in-flight fetch is unaffected.
  - id_stall && !flush && !redirect: IF/ID holds all values.
  - !id_stall with no new word: id_valid<=0 (bubble).
- Priority: rst > redirect_valid > id_flush > id_stall.
- Latency and throughput:
  - With imem_ready=1 and rvalid one cycle after acceptance, id_valid rises 2 edges after the request cycle.
  - Peak throughput is 1 instruction per 2 cycles.
- Data path rule: id_pc_plus4 is registered together with id_pc.
- Invariants:
  - imem_addr[1:0] == 0 always.
  - imem_rvalid outside WAIT is ignored.

Decomposition:
- Shared core package holds:
  - NOP_INSTR and RESET_PC default constants.
  - The fetch FSM state encodings (REQ=2'd0, WAIT=2'd1, HOLD=2'd2).
  - XLEN=32.
- One sub-module: if_id_reg, the pipeline register with stall/flush/NOP-insertion for instr, pc and pc_plus4. It is reused for later pipeline registers.

Test Plan:
- Reset/first fetch: assert rst 2 cycles, then release with imem_ready=1 and a 1-cycle response latency returning 0x00500093 -> imem_req=1 with addr 0x0 the cycle after reset; id_valid=1, id_instr=0x00500093, id_pc=0, id_pc_plus4=4 two edges later; next request addr 0x4.
- Stall with skid: hold id_stall=1 while a valid instruction sits in IF/ID and the next response (pc 0x8, data 0x00A00113) arrives -> FSM enters HOLD; IF/ID is unchanged; imem_req=0; releasing the stall loads id_pc=0x8 on the next edge.
- Redirect during WAIT: redirect_valid=1 with redirect_pc=0x100 while waiting; the response arrives 2 cycles later -> that data is discarded and never shows id_valid=1; the next request addr is 0x100.
- Redirect with misaligned target and simultaneous id_stall: redirect_pc=0x203 with id_stall=1 -> id_valid=0 next edge; the next imem_addr is 0x200.
- id_flush alone: assert id_flush for one cycle with id_valid=1 -> id_valid=0 and id_instr=0x00000013; the fetch stream continues at pc+4 with no lost request.
- PC wrap and slow memory: redirect to 0xFFFFFFFC and hold imem_ready=0 for 3 cycles -> imem_req stays high with a stable address; after acceptance the next address is 0x00000000.
